packed_dot_product_engine: RTL and testbench



---
 rtl/packed_dot_product_engine.sv | 353 +++++++++++++++++++++++++++++++++++
 tb/tb_packed_dot_product_engine.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/packed_dot_product_engine.sv
// ---------------------------------------------------------------------------
// packed_dot_product_engine
//
// Reads a 3-word header (N, element size S, channel count M) from the input
// SRAM. For each of the M channels it streams the packed signed input vector
// from SRAM and that channel's packed weights from WMEM. It accumulates the
// signed dot product, saturates it to 16 bits, and writes it back to SRAM at
// OUT_BASE+k.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   dut_run / dut_busy         start request / run in progress
//   dut_sram_read_address      input SRAM read address (data 1 cycle later)
//   sram_dut_read_data         input SRAM read data
//   dut_wmem_read_address      weight memory read address (data 1 cycle later)
//   wmem_dut_read_data         weight memory read data
//   dut_sram_write_address     result write address
//   dut_sram_write_data        saturated result
//   dut_sram_write_enable      one-cycle write strobe
// ---------------------------------------------------------------------------
module packed_dot_product_engine #(
    parameter int                ADDR_W    = 12,
    parameter int                DATA_W    = 16,
    parameter int                ACC_W     = 40,
    parameter logic [ADDR_W-1:0] IN_BASE   = {ADDR_W{1'b0}},
    parameter logic [ADDR_W-1:0] WMEM_BASE = {ADDR_W{1'b0}},
    parameter logic [ADDR_W-1:0] OUT_BASE  = 12'h800
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dut_run,
    output logic              dut_busy,
    output logic [ADDR_W-1:0] dut_sram_read_address,
    input  logic [DATA_W-1:0] sram_dut_read_data,
    output logic [ADDR_W-1:0] dut_wmem_read_address,
    input  logic [DATA_W-1:0] wmem_dut_read_data,
    output logic [ADDR_W-1:0] dut_sram_write_address,
    output logic [DATA_W-1:0] dut_sram_write_data,
    output logic              dut_sram_write_enable
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_MAC   = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Element-size modes: 16-bit (1 lane), 8-bit (2 lanes), 4-bit (4 lanes)
    localparam logic [1:0] MODE_16 = 2'd0;
    localparam logic [1:0] MODE_8  = 2'd1;
    localparam logic [1:0] MODE_4  = 2'd2;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32'sd32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32'sd32768);

    // Sum of the lane products of one packed word pair; masked lanes add 0.
    function automatic logic signed [33:0] word_dot(input logic [15:0] a,
                                                    input logic [15:0] b,
                                                    input logic [1:0]  mode,
                                                    input logic [3:0]  mask);
        logic signed [33:0] sum;
        logic signed [33:0] ea;
        logic signed [33:0] eb;
        sum = 34'sd0;
        case (mode)
            MODE_4: begin
                for (int l = 0; l < 4; l++) begin
                    ea = {{30{a[4*l+3]}}, a[4*l +: 4]};
                    eb = {{30{b[4*l+3]}}, b[4*l +: 4]};
                    if (mask[l]) sum = sum + ea * eb;
                    else         sum = sum;
                end
            end
            MODE_8: begin
                for (int l = 0; l < 2; l++) begin
                    ea = {{26{a[8*l+7]}}, a[8*l +: 8]};
                    eb = {{26{b[8*l+7]}}, b[8*l +: 8]};
                    if (mask[l]) sum = sum + ea * eb;
                    else         sum = sum;
                end
            end
            default: begin
                ea = {{18{a[15]}}, a};
                eb = {{18{b[15]}}, b};
                if (mask[0]) sum = ea * eb;
                else         sum = 34'sd0;
            end
        endcase
        return sum;
    endfunction

    // Clamp the accumulator into the signed 16-bit range.
    function automatic logic [15:0] sat16(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX)      return 16'h7FFF;
        else if (v < SAT_MIN) return 16'h8000;
        else                  return v[15:0];
    endfunction

    state_t                    state_r,   state_s;
    logic [1:0]                hcnt_r,    hcnt_s;
    logic [15:0]               n_r,       n_s;
    logic [1:0]                mode_r,    mode_s;
    logic [15:0]               m_r,       m_s;
    logic [15:0]               words_r,   words_s;
    logic [15:0]               k_r,       k_s;
    logic [15:0]               cnt_r,     cnt_s;
    logic [15:0]               rem_r,     rem_s;
    logic                      v1_r,      v1_s;
    logic                      v2_r,      v2_s;
    logic signed [ACC_W-1:0]   acc_r,     acc_s;
    logic [ADDR_W-1:0]         in_addr_r, in_addr_s;
    logic [ADDR_W-1:0]         w_addr_r,  w_addr_s;
    logic [ADDR_W-1:0]         wbase_r,   wbase_s;
    logic                      busy_r,    busy_s;
    logic                      we_r,      we_s;
    logic [ADDR_W-1:0]         wr_addr_r, wr_addr_s;
    logic [15:0]               wr_data_r, wr_data_s;

    logic                      start_ch_s;
    logic [ADDR_W-1:0]         start_base_s;
    logic [15:0]               start_words_s;
    logic [1:0]                round_s;
    logic [1:0]                shamt_s;
    logic [16:0]               wsum_s;
    logic [15:0]               words_calc_s;
    logic [15:0]               e_s;
    logic [3:0]                lane_mask_s;
    logic signed [33:0]        word_sum_s;

    // Lanes still inside the vector for the word being accumulated.
    assign lane_mask_s = {rem_r > 16'd3, rem_r > 16'd2, rem_r > 16'd1, rem_r > 16'd0};
    assign word_sum_s  = word_dot(sram_dut_read_data, wmem_dut_read_data, mode_r, lane_mask_s);

    // Per-mode lane count and ceil(N/E) as (N + E-1) >> log2(E).
    always_comb begin
        round_s = 2'd0;
        shamt_s = 2'd0;
        e_s     = 16'd1;
        case (mode_r)
            MODE_4: begin
                round_s = 2'd3;
                shamt_s = 2'd2;
                e_s     = 16'd4;
            end
            MODE_8: begin
                round_s = 2'd1;
                shamt_s = 2'd1;
                e_s     = 16'd2;
            end
            default: begin
                round_s = 2'd0;
                shamt_s = 2'd0;
                e_s     = 16'd1;
            end
        endcase
        wsum_s       = {1'b0, n_r} + {15'd0, round_s};
        words_calc_s = 16'(wsum_s >> shamt_s);
    end

    // Next-state and next-register logic for the control FSM and datapath.
    always_comb begin
        state_s       = state_r;
        hcnt_s        = hcnt_r;
        n_s           = n_r;
        mode_s        = mode_r;
        m_s           = m_r;
        words_s       = words_r;
        k_s           = k_r;
        cnt_s         = cnt_r;
        rem_s         = rem_r;
        v1_s          = v1_r;
        v2_s          = v2_r;
        acc_s         = acc_r;
        in_addr_s     = in_addr_r;
        w_addr_s      = w_addr_r;
        wbase_s       = wbase_r;
        busy_s        = busy_r;
        we_s          = 1'b0;
        wr_addr_s     = wr_addr_r;
        wr_data_s     = wr_data_r;
        start_ch_s    = 1'b0;
        start_base_s  = wbase_r;
        start_words_s = words_r;

        case (state_r)
            ST_IDLE: begin
                if (dut_run) begin
                    state_s   = ST_HDR;
                    busy_s    = 1'b1;
                    in_addr_s = IN_BASE;
                    hcnt_s    = 2'd0;
                    k_s       = 16'd0;
                end else begin
                    busy_s    = 1'b0;
                end
            end
            ST_HDR: begin
                // Header reads are issued on hcnt 0..2 (address register
                // already holds word 0); data lands two edges after issue.
                case (hcnt_r)
                    2'd0: begin
                        in_addr_s = IN_BASE + ADDR_W'(2'd1);
                        hcnt_s    = 2'd1;
                    end
                    2'd1: begin
                        in_addr_s = IN_BASE + ADDR_W'(2'd2);
                        n_s       = sram_dut_read_data;
                        hcnt_s    = 2'd2;
                    end
                    2'd2: begin
                        case (sram_dut_read_data)
                            16'd4:   mode_s = MODE_4;
                            16'd8:   mode_s = MODE_8;
                            default: mode_s = MODE_16;
                        endcase
                        hcnt_s = 2'd3;
                    end
                    default: begin
                        if (sram_dut_read_data == 16'd0) m_s = 16'd1;
                        else                             m_s = sram_dut_read_data;
                        words_s       = words_calc_s;
                        start_ch_s    = 1'b1;
                        start_base_s  = WMEM_BASE;
                        start_words_s = words_calc_s;
                        state_s       = ST_MAC;
                    end
                endcase
            end
            ST_MAC: begin
                if (v2_r) begin
                    acc_s = acc_r + ACC_W'(word_sum_s);
                    if (rem_r > e_s) rem_s = rem_r - e_s;
                    else             rem_s = 16'd0;
                end else begin
                    acc_s = acc_r;
                end
                if (cnt_r != words_r) begin
                    in_addr_s = in_addr_r + ADDR_W'(1'b1);
                    w_addr_s  = w_addr_r + ADDR_W'(1'b1);
                    cnt_s     = cnt_r + 16'd1;
                    v1_s      = 1'b1;
                end else begin
                    v1_s      = 1'b0;
                end
                v2_s = v1_r;
                // All reads issued and the last returning pair is in this edge.
                if ((cnt_r == words_r) && !v1_r) begin
                    state_s   = ST_WRITE;
                    we_s      = 1'b1;
                    wr_addr_s = OUT_BASE + ADDR_W'(k_r);
                    wr_data_s = sat16(acc_s);
                end else begin
                    state_s   = ST_MAC;
                end
            end
            ST_WRITE: begin
                k_s = k_r + 16'd1;
                if (k_s < m_r) begin
                    start_ch_s    = 1'b1;
                    start_base_s  = wbase_r + ADDR_W'(words_r);
                    start_words_s = words_r;
                    state_s       = ST_MAC;
                end else begin
                    state_s       = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
            default: begin
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
        endcase

        // Channel start: clear the accumulator and present the first read
        // pair so the MAC loop streams without a bubble. With W=0 the read
        // addresses are left untouched.
        if (start_ch_s) begin
            acc_s   = {ACC_W{1'b0}};
            rem_s   = n_r;
            v2_s    = 1'b0;
            wbase_s = start_base_s;
            if (start_words_s != 16'd0) begin
                in_addr_s = IN_BASE + ADDR_W'(2'd3);
                w_addr_s  = start_base_s;
                cnt_s     = 16'd1;
                v1_s      = 1'b1;
            end else begin
                cnt_s     = 16'd0;
                v1_s      = 1'b0;
            end
        end else begin
            wbase_s = wbase_s;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            hcnt_r    <= 2'd0;
            n_r       <= 16'd0;
            mode_r    <= MODE_16;
            m_r       <= 16'd0;
            words_r   <= 16'd0;
            k_r       <= 16'd0;
            cnt_r     <= 16'd0;
            rem_r     <= 16'd0;
            v1_r      <= 1'b0;
            v2_r      <= 1'b0;
            acc_r     <= {ACC_W{1'b0}};
            in_addr_r <= {ADDR_W{1'b0}};
            w_addr_r  <= {ADDR_W{1'b0}};
            wbase_r   <= {ADDR_W{1'b0}};
            busy_r    <= 1'b0;
            we_r      <= 1'b0;
            wr_addr_r <= {ADDR_W{1'b0}};
            wr_data_r <= 16'd0;
        end else begin
            state_r   <= state_s;
            hcnt_r    <= hcnt_s;
            n_r       <= n_s;
            mode_r    <= mode_s;
            m_r       <= m_s;
            words_r   <= words_s;
            k_r       <= k_s;
            cnt_r     <= cnt_s;
            rem_r     <= rem_s;
            v1_r      <= v1_s;
            v2_r      <= v2_s;
            acc_r     <= acc_s;
            in_addr_r <= in_addr_s;
            w_addr_r  <= w_addr_s;
            wbase_r   <= wbase_s;
            busy_r    <= busy_s;
            we_r      <= we_s;
            wr_addr_r <= wr_addr_s;
            wr_data_r <= wr_data_s;
        end
    end

    assign dut_busy               = busy_r;
    assign dut_sram_read_address  = in_addr_r;
    assign dut_wmem_read_address  = w_addr_r;
    assign dut_sram_write_address = wr_addr_r;
    assign dut_sram_write_data    = wr_data_r;
    assign dut_sram_write_enable  = we_r;

endmodule

// File: tb/tb_packed_dot_product_engine.sv
// ---------------------------------------------------------------------------
// tb_packed_dot_product_engine
//
// Models the SRAM and WMEM with one-cycle read latency. Expected writes
// ({address, data}) are queued before each run and popped as the DUT strobes
// dut_sram_write_enable.
// ---------------------------------------------------------------------------
module tb_packed_dot_product_engine;

    localparam logic [11:0] OUT_BASE = 12'h800;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dut_run = 1'b0;
    logic        dut_busy;
    logic [11:0] dut_sram_read_address;
    logic [15:0] sram_dut_read_data;
    logic [11:0] dut_wmem_read_address;
    logic [15:0] wmem_dut_read_data;
    logic [11:0] dut_sram_write_address;
    logic [15:0] dut_sram_write_data;
    logic        dut_sram_write_enable;

    logic [15:0] sram [0:4095];
    logic [15:0] wmem [0:4095];

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [27:0] exp_q[$];
    logic [27:0] exp_w;
    bit          wmem_watch = 1'b0;
    bit          wmem_moved = 1'b0;
    logic [11:0] wmem_ref = 12'd0;

    packed_dot_product_engine dut (
        .clk                    (clk),
        .reset                  (reset),
        .dut_run                (dut_run),
        .dut_busy               (dut_busy),
        .dut_sram_read_address  (dut_sram_read_address),
        .sram_dut_read_data     (sram_dut_read_data),
        .dut_wmem_read_address  (dut_wmem_read_address),
        .wmem_dut_read_data     (wmem_dut_read_data),
        .dut_sram_write_address (dut_sram_write_address),
        .dut_sram_write_data    (dut_sram_write_data),
        .dut_sram_write_enable  (dut_sram_write_enable)
    );

    always #5 clk = ~clk;

    // Memory models: registered read, data valid the cycle after the address.
    always @(posedge clk) begin
        sram_dut_read_data <= sram[dut_sram_read_address];
        wmem_dut_read_data <= wmem[dut_wmem_read_address];
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: compare each write strobe with the oldest expected write.
    always @(negedge clk) begin
        if (dut_sram_write_enable === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_write", 32'(exp_q.size()), 32'd1);
            end else begin
                exp_w = exp_q.pop_front();
                check_val("wr_addr", 32'(dut_sram_write_address), 32'(exp_w[27:16]));
                check_val("wr_data", 32'(dut_sram_write_data), 32'(exp_w[15:0]));
            end
        end
        if (wmem_watch && (dut_wmem_read_address !== wmem_ref)) wmem_moved = 1'b1;
    end

    function automatic longint sext(input longint v, input int sz);
        longint x;
        x = v & ((longint'(1) << sz) - 1);
        if (x >= (longint'(1) << (sz - 1))) x = x - (longint'(1) << sz);
        return x;
    endfunction

    function automatic int lanes_of(input int s);
        if (s == 4)      return 4;
        else if (s == 8) return 2;
        else             return 1;
    endfunction

    // Element-by-element reference dot product for every channel.
    task automatic push_model(input int n, input int s, input int m);
        int     e, sz, w, meff, word, lane;
        longint sum, iv, wv;
        e    = lanes_of(s);
        sz   = 16 / e;
        w    = (n + e - 1) / e;
        meff = (m == 0) ? 1 : m;
        for (int k = 0; k < meff; k++) begin
            sum = 0;
            for (int i = 0; i < n; i++) begin
                word = i / e;
                lane = i % e;
                iv   = sext(longint'(sram[3 + word]) >> (lane * sz), sz);
                wv   = sext(longint'(wmem[k * w + word]) >> (lane * sz), sz);
                sum  = sum + iv * wv;
            end
            if (sum > 32767)  sum = 32767;
            if (sum < -32768) sum = -32768;
            exp_q.push_back({OUT_BASE + 12'(k), 16'(sum)});
        end
    endtask

    task automatic run_job(input int n, input int s, input int m);
        int e, w, meff, bound, cyc;
        e     = lanes_of(s);
        w     = (n + e - 1) / e;
        meff  = (m == 0) ? 1 : m;
        bound = 4 + meff * (w + 3) + 2;
        sram[0] = 16'(n);
        sram[1] = 16'(s);
        sram[2] = 16'(m);
        @(negedge clk) dut_run = 1'b1;
        @(negedge clk) dut_run = 1'b0;
        check_val("busy_rise", 32'(dut_busy), 32'd1);
        cyc = 1;
        while (dut_busy && cyc < bound) begin
            @(negedge clk);
            cyc++;
        end
        check_val("busy_fall", 32'(dut_busy), 32'd0);
        check_val("writes_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic load_multi();
        sram[3] = 16'd3;
        sram[4] = 16'd5;
        wmem[0] = 16'd1;
        wmem[1] = 16'd1;
        wmem[2] = 16'd2;
        wmem[3] = 16'hFFFF;
    endtask

    initial begin
        int n, s, m, e, w;
        for (int i = 0; i < 4096; i++) begin
            sram[i] = 16'd0;
            wmem[i] = 16'd0;
        end
        repeat (3) @(negedge clk);
        check_val("rst_busy", 32'(dut_busy), 32'd0);
        check_val("rst_we", 32'(dut_sram_write_enable), 32'd0);
        check_val("rst_rd_addr", 32'(dut_sram_read_address), 32'd0);
        check_val("rst_wm_addr", 32'(dut_wmem_read_address), 32'd0);
        check_val("rst_wr_addr", 32'(dut_sram_write_address), 32'd0);
        check_val("rst_wr_data", 32'(dut_sram_write_data), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 8-bit lanes
        sram[3] = 16'h0201; sram[4] = 16'h0403;
        wmem[0] = 16'hFF02; wmem[1] = 16'h0301;
        exp_q.push_back({OUT_BASE, 16'h000F});
        run_job(4, 8, 1);

        // 4-bit signed lanes
        sram[3] = 16'h4321; wmem[0] = 16'hF111;
        exp_q.push_back({OUT_BASE, 16'h0002});
        run_job(4, 4, 1);

        // two 16-bit channels
        load_multi();
        exp_q.push_back({OUT_BASE, 16'h0008});
        exp_q.push_back({OUT_BASE + 12'd1, 16'h0001});
        run_job(2, 16, 2);

        // positive saturation
        sram[3] = 16'h7FFF; sram[4] = 16'h7FFF;
        wmem[0] = 16'h7FFF; wmem[1] = 16'h7FFF;
        exp_q.push_back({OUT_BASE, 16'h7FFF});
        run_job(2, 16, 1);

        // partial final word, lane past N ignored
        sram[3] = 16'h0101; sram[4] = 16'h7F01;
        wmem[0] = 16'h0101; wmem[1] = 16'h0501;
        exp_q.push_back({OUT_BASE, 16'h0003});
        run_job(3, 8, 1);

        // N=0: three zero results, weight address never moves
        exp_q.push_back({OUT_BASE, 16'h0000});
        exp_q.push_back({OUT_BASE + 12'd1, 16'h0000});
        exp_q.push_back({OUT_BASE + 12'd2, 16'h0000});
        wmem_ref   = dut_wmem_read_address;
        wmem_moved = 1'b0;
        wmem_watch = 1'b1;
        run_job(0, 8, 3);
        wmem_watch = 1'b0;
        check_val("wmem_idle", 32'(wmem_moved), 32'd0);

        // reset during channel 0 MAC; no writes may follow
        load_multi();
        sram[0] = 16'd2; sram[1] = 16'd16; sram[2] = 16'd2;
        @(negedge clk) dut_run = 1'b1;
        @(negedge clk) dut_run = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        check_val("abort_busy", 32'(dut_busy), 32'd0);
        check_val("abort_we", 32'(dut_sram_write_enable), 32'd0);
        repeat (12) @(negedge clk);
        check_val("abort_busy_late", 32'(dut_busy), 32'd0);
        exp_q.push_back({OUT_BASE, 16'h0008});
        exp_q.push_back({OUT_BASE + 12'd1, 16'h0001});
        run_job(2, 16, 2);

        // random configurations against the reference model
        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(0, 20);
            case ($urandom_range(0, 3))
                0:       s = 4;
                1:       s = 8;
                2:       s = 16;
                default: s = 5;
            endcase
            m = $urandom_range(0, 3);
            e = lanes_of(s);
            w = (n + e - 1) / e;
            for (int i = 0; i < 64; i++) begin
                sram[3 + i] = 16'($urandom);
                wmem[i]     = 16'($urandom);
            end
            push_model(n, s, m);
            run_job(n, s, m);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
